fpadd_seq_ctrl: RTL and testbench
=================================

FPADD_SEQ_CTRL -- requirements
Module: fpadd_seq_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2: cycles from add_src/add_mode presentation to valid add_result (1..8).
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operation request.
REQ-006 SHALL have port in_ready, output, 1: operation accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have port in_src0 / in_src1, input, 128 each: packed operands.
REQ-008 SHALL have port in_mode, input, 1: 0 = 8 lanes of fp16, 1 = 4 lanes of fp32.
REQ-009 SHALL have port in_tag, input, 4: opaque operation ID.
REQ-010 SHALL have port add_src0 / add_src1, output, 128 each: to subword adder.
REQ-011 SHALL have port add_mode, output, 1: adder output-select flag.
REQ-012 SHALL have port add_result, input, 128: adder output.
REQ-013 SHALL have port out_valid / out_ready, output / input, 1: result handshake.
REQ-014 SHALL have port out_result, output, 128; out_tag, output, 4; out_mode, output, 1.
REQ-015 SHALL have port flush_req, input, 1; flush_done, output, 1.

Function
REQ-016 SHALL register in_src0/in_src1 into add_src0/add_src1 on accept; it SHALL hold them unchanged otherwise.
REQ-017 SHALL track in-flight ops in a LAT-stage valid/tag/mode shift pipe; an op accepted at edge E presents on add_src in cycle E+1 and its result is valid in cycle E+1+LAT.
REQ-018 SHALL drive add_mode in cycle E+1+LAT with that op's in_mode (the adder's output mux is post-pipeline); add_mode SHALL hold its last value when no result is emerging.
REQ-019 SHALL push {add_result, tag, mode} into the FIFO at the end of cycle E+1+LAT; there is no FIFO bypass, so the minimum accept-to-out_valid latency is LAT+2 cycles.
REQ-020 SHALL compute in_ready = (state==RUN) and (fifo_count + inflight_count < DEPTH); this credit rule guarantees the FIFO never overflows and no result is ever dropped.
REQ-021 SHALL treat simultaneous FIFO push and pop as count-neutral; pointers wrap modulo DEPTH.
REQ-022 SHALL hold out_valid, out_result, out_tag and out_mode stable while out_valid and not out_ready.
REQ-023 SHALL present results in acceptance order; back-to-back accepts SHALL sustain one op per cycle when out_ready is held high.
REQ-024 SHALL implement an FSM with states RUN, DRAIN and DONE:
- RUN -> DRAIN when flush_req is high (in_ready low from the next cycle).
- DRAIN -> DONE when inflight_count==0 and the FIFO is empty.
- DONE -> RUN unconditionally after one cycle.
REQ-025 SHALL assert flush_done for exactly one cycle, in DONE.
REQ-026 SHALL ignore flush_req outside RUN; an accept on the same edge flush_req is first seen SHALL still complete.

Reset
REQ-027 SHALL, on an edge with rst_n low, set the FSM to RUN, empty the FIFO, and clear the in-flight pipe, add_src0/add_src1 (0), add_mode (0), out_valid (0) and flush_done (0).
REQ-028 SHALL discard in-flight ops and buffered results on reset mid-operation; no stale result SHALL appear afterwards.
REQ-029 SHALL drive in_ready to 0 during reset and to 1 on the first cycle after rst_n rises.

Configuration
REQ-030 SHALL, when FPADD_SEQ_PERF_EN is defined, add output perf_ops[15:0] (accepts) and output perf_stall[15:0] (cycles with in_valid high and in_ready low). Both counters SHALL saturate at 16'hFFFF and clear on reset.
REQ-031 SHALL, when FPADD_SEQ_PERF_EN is undefined, have neither port nor counter logic, with all other behaviour identical.

Verification
REQ-032 SHALL be verified by: LAT=2; one fp32 op with tag 3 and out_ready=1 -> out_valid in cycle E+4, out_tag=3, out_mode=1, out_result = adder model output.
REQ-033 SHALL be verified by: alternating fp16/fp32 ops every cycle -> add_mode toggles each cycle aligned with add_result; out_mode sequence 0,1,0,1,...
REQ-034 SHALL be verified by: out_ready=0 with continuous in_valid, DEPTH=4 -> exactly 4 accepts, then in_ready=0; releasing out_ready yields tags in order with none lost.
REQ-035 SHALL be verified by: flush_req with 3 ops pending and out_ready=1 -> in_ready=0 until all 3 results are popped, then a single-cycle flush_done, then in_ready=1.
REQ-036 SHALL be verified by: rst_n low for one cycle with 2 ops in flight -> out_valid=0 and no result emerges for 10 cycles.
REQ-037 SHALL be verified by: FPADD_SEQ_PERF_EN defined; 5 accepts and 7 stall cycles -> perf_ops=5, perf_stall=7.

Source files
------------

// File: rtl/fpadd_seq_ctrl.sv
// Issue sequencer for an external LAT-cycle subword fp adder: operand staging, in-flight
// tracking, credit-gated result FIFO and flush FSM. Optional counters: FPADD_SEQ_PERF_EN.
module fpadd_seq_ctrl #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_src0,
    input  logic [127:0] in_src1,
    input  logic         in_mode,
    input  logic [3:0]   in_tag,
    output logic [127:0] add_src0,
    output logic [127:0] add_src1,
    output logic         add_mode,
    input  logic [127:0] add_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_result,
    output logic [3:0]   out_tag,
    output logic         out_mode,
    input  logic         flush_req,
    output logic         flush_done
`ifdef FPADD_SEQ_PERF_EN
    ,
    output logic [15:0]  perf_ops,
    output logic [15:0]  perf_stall
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = 6;

    typedef struct packed {
        logic [127:0] result;
        logic [3:0]   tag;
        logic         mode;
    } res_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, push, pop;
    logic [LAT:0]      vld_pipe;
    logic [LAT:0][3:0] tag_pipe;
    logic [LAT:0]      mode_pipe;
    logic [SW-1:0]     inflight_cnt;
    logic [CW-1:0]     fifo_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    res_t              fifo_mem [DEPTH];
    res_t              head;

    // Every accepted op that has not yet been popped holds one credit, so the FIFO cannot overflow.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= LAT; i++) inflight_cnt = inflight_cnt + SW'(vld_pipe[i]);
    end

    assign in_ready = rst_n && (state == RUN) && ((SW'(fifo_cnt) + inflight_cnt) < SW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = vld_pipe[LAT];
    assign out_valid = (fifo_cnt != '0);
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_src0 <= '0;
            add_src1 <= '0;
        end else if (accept) begin
            add_src0 <= in_src0;
            add_src1 <= in_src1;
        end
    end

    // Stage k holds the op whose operands entered the adder k cycles ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            tag_pipe  <= '0;
            mode_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[LAT-1:0], accept};
            tag_pipe  <= {tag_pipe[LAT-1:0], in_tag};
            mode_pipe <= {mode_pipe[LAT-1:0], in_mode};
        end
    end

    // The adder's output select sits after its pipeline, so it is set as the result emerges.
    always_ff @(posedge clk) begin
        if (!rst_n) add_mode <= 1'b0;
        else if (vld_pipe[LAT-1]) add_mode <= mode_pipe[LAT-1];
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{result: add_result, tag: tag_pipe[LAT], mode: mode_pipe[LAT]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign out_result = head.result;
    assign out_tag    = head.tag;
    assign out_mode   = head.mode;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN:   if (flush_req) state_nxt = DRAIN;
            DRAIN: if (inflight_cnt == '0 && fifo_cnt == '0) state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

`ifdef FPADD_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
            if (in_valid && !in_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// Bench for fpadd_seq_ctrl: lane-adder stand-in, queue-based reference model, scenario tasks.
module tb_fpadd_seq_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         clk, rst_n, in_valid, in_ready, in_mode, add_mode;
    logic         out_valid, out_ready, out_mode, flush_req, flush_done;
    logic [127:0] in_src0, in_src1, add_src0, add_src1, add_result, out_result;
    logic [3:0]   in_tag, out_tag;
`ifdef FPADD_SEQ_PERF_EN
    logic [15:0]  perf_ops, perf_stall;
`endif

    fpadd_seq_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src0(in_src0), .in_src1(in_src1), .in_mode(in_mode), .in_tag(in_tag),
        .add_src0(add_src0), .add_src1(add_src1), .add_mode(add_mode), .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_mode(out_mode), .flush_req(flush_req), .flush_done(flush_done)
`ifdef FPADD_SEQ_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] sum16(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r;
    endfunction

    function automatic logic [127:0] sum32(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
        return r;
    endfunction

    // Adder stand-in: LAT register stages, output lane width chosen by add_mode.
    logic [127:0] p16 [1:LAT];
    logic [127:0] p32 [1:LAT];
    always @(posedge clk) begin
        p16[1] <= sum16(add_src0, add_src1);
        p32[1] <= sum32(add_src0, add_src1);
        for (int i = 2; i <= LAT; i++) begin
            p16[i] <= p16[i-1];
            p32[i] <= p32[i-1];
        end
    end
    assign add_result = add_mode ? p32[LAT] : p16[LAT];

    typedef struct {
        logic [127:0] res;
        logic [3:0]   tag;
        logic         mode;
        int           acc;
        int           avail;
    } ent_t;

    ent_t q[$];
    int   edges = 0;
    int   mst = 0;  // 0 running, 1 draining, 2 flush complete
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic bit m_ready();
        return rst_n && (mst == 0) && (q.size() < DEPTH);
    endfunction

    function automatic bit m_ovalid();
        return (q.size() > 0) && (q[0].avail <= edges);
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_op(input bit mode, input logic [3:0] tag);
        in_valid = 1'b1;
        in_src0  = r128();
        in_src1  = r128();
        in_mode  = mode;
        in_tag   = tag;
    endtask

    // Advance the reference model over the coming edge, then move to the next negedge.
    task automatic tick();
        ent_t e;
        bit   acc, pp;
        if (!rst_n) begin
            q.delete();
            mst = 0;
        end else begin
            acc = in_valid && m_ready();
            pp  = m_ovalid() && out_ready;
            case (mst)
                0: if (flush_req) mst = 1;
                1: if (q.size() == 0) mst = 2;
                default: mst = 0;
            endcase
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.res   = in_mode ? sum32(in_src0, in_src1) : sum16(in_src0, in_src1);
                e.tag   = in_tag;
                e.mode  = in_mode;
                e.acc   = edges;
                e.avail = edges + LAT + 2;
                q.push_back(e);
            end
        end
        @(negedge clk);
        edges++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush_req = 1'b0;
        in_src0 = '0; in_src1 = '0; in_mode = 1'b0; in_tag = '0;
        tick(); tick();
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        n_chk++; if (add_src0 !== '0 || add_src1 !== '0) begin n_fail++; $display("FAIL reset_add_src: got %h/%h want 0", add_src0, add_src1); end
        n_chk++; if (add_mode !== 1'b0) begin n_fail++; $display("FAIL reset_add_mode: got %b want 0", add_mode); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [127:0] exp_res, got_res;
        logic [3:0]   got_tag;
        logic         got_mode;
        int           first;
        out_ready = 1'b1;
        drive_op(1'b1, 4'd3);
        exp_res = sum32(in_src0, in_src1);
        tick();
        in_valid = 1'b0;
        first = 0; got_res = '0; got_tag = '0; got_mode = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid && first == 0) begin
                first = c; got_res = out_result; got_tag = out_tag; got_mode = out_mode;
            end
            tick();
        end
        n_chk++; if (first != LAT + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first, LAT + 2); end
        n_chk++; if (got_tag !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %0d want 3", got_tag); end
        n_chk++; if (got_mode !== 1'b1) begin n_fail++; $display("FAIL single_mode: got %b want 1", got_mode); end
        n_chk++; if (got_res !== exp_res) begin n_fail++; $display("FAIL single_result: got %h want %h", got_res, exp_res); end
    endtask

    task automatic test_alternate();
        int sent = 0, popped = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && (sent < 12 || q.size() > 0); c++) begin
            if (sent < 12) drive_op(sent[0], 4'(sent)); else in_valid = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].acc + LAT + 1 == edges) begin
                    n_chk++; if (add_mode !== q[i].mode) begin n_fail++; $display("FAIL alt_add_mode: got %b want %b", add_mode, q[i].mode); end
                    n_chk++; if (add_result !== q[i].res) begin n_fail++; $display("FAIL alt_add_result: got %h want %h", add_result, q[i].res); end
                end
            end
            if (out_valid) begin
                n_chk++; if (out_mode !== popped[0]) begin n_fail++; $display("FAIL alt_out_mode: got %b want %b at %0d", out_mode, popped[0], popped); end
                popped++;
            end
            if (in_valid && m_ready()) sent++;
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (popped != 12) begin n_fail++; $display("FAIL alt_count: got %0d want 12", popped); end
    endtask

    task automatic test_backpressure();
        int           accepts = 0, got = 0;
        bit           snap = 0;
        logic [127:0] s_res;
        logic [3:0]   s_tag;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_op(1'($urandom), 4'(c));
            if (in_ready) accepts++;
            if (out_valid && snap) begin
                n_chk++; if (out_result !== s_res || out_tag !== s_tag) begin n_fail++; $display("FAIL bp_hold: got %0d/%h want %0d/%h", out_tag, out_result, s_tag, s_res); end
            end
            if (out_valid && !snap) begin snap = 1; s_res = out_result; s_tag = out_tag; end
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (accepts != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", accepts, DEPTH); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                n_chk++; if (out_tag !== 4'(got)) begin n_fail++; $display("FAIL bp_order: got %0d want %0d", out_tag, got); end
                got++;
            end
            tick();
        end
        n_chk++; if (got != DEPTH) begin n_fail++; $display("FAIL bp_drained: got %0d want %0d", got, DEPTH); end
    endtask

    task automatic test_flush();
        int  pops = 0, fd = 0;
        bit  after = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin drive_op(1'($urandom), 4'(k + 8)); tick(); end
        in_valid = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 30 && !after; c++) begin
            if (pops < 3) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0 with %0d popped", in_ready, pops); end
            end
            if (flush_done) begin
                fd++;
                n_chk++; if (pops != 3) begin n_fail++; $display("FAIL flush_early: got %0d popped want 3", pops); end
            end else if (fd > 0) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resume: got %b want 1", in_ready); end
                after = 1;
            end
            if (out_valid) pops++;
            tick();
        end
        n_chk++; if (fd != 1) begin n_fail++; $display("FAIL flush_done_width: got %0d cycles want 1", fd); end
        n_chk++; if (!after) begin n_fail++; $display("FAIL flush_return: got no RUN want RUN"); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin drive_op(1'b0, 4'(k)); tick(); end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0 at %0d", out_valid, c); end
            tick();
        end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 220; c++) begin
            if (c < 200) begin
                if ($urandom_range(3) != 0) drive_op(1'($urandom), 4'($urandom)); else in_valid = 1'b0;
                out_ready = ($urandom_range(2) != 0);
                flush_req = ($urandom_range(39) == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; flush_req = 1'b0;
            end
            n_chk++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready: got %b want %b cyc %0d", in_ready, m_ready(), c); end
            n_chk++; if (out_valid !== m_ovalid()) begin n_fail++; $display("FAIL rnd_out_valid: got %b want %b cyc %0d", out_valid, m_ovalid(), c); end
            n_chk++; if (flush_done !== (mst == 2)) begin n_fail++; $display("FAIL rnd_flush_done: got %b want %b cyc %0d", flush_done, mst == 2, c); end
            if (m_ovalid()) begin
                n_chk++;
                if (out_tag !== q[0].tag || out_mode !== q[0].mode || out_result !== q[0].res) begin
                    n_fail++;
                    $display("FAIL rnd_data: got %0d/%b/%h want %0d/%b/%h", out_tag, out_mode, out_result, q[0].tag, q[0].mode, q[0].res);
                end
            end
            tick();
        end
        n_chk++; if (q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got %0d/%b want 0/0", q.size(), out_valid); end
    endtask

`ifdef FPADD_SEQ_PERF_EN
    task automatic test_perf();
        in_valid = 1'b0; out_ready = 1'b0; flush_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_chk++; if (perf_ops !== 16'd0 || perf_stall !== 16'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_ops, perf_stall); end
        for (int c = 0; c < 11; c++) begin drive_op(1'b1, 4'(c)); tick(); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        drive_op(1'b0, 4'd15);
        tick();
        in_valid = 1'b0;
        n_chk++; if (perf_ops !== 16'd5) begin n_fail++; $display("FAIL perf_ops: got %0d want 5", perf_ops); end
        n_chk++; if (perf_stall !== 16'd7) begin n_fail++; $display("FAIL perf_stall: got %0d want 7", perf_stall); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef FPADD_SEQ_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
